// File: rtl/am29xx_pkg.sv
// Shared definitions for the am29xx-style bus port blocks: turnaround FSM state encoding.
package am29xx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AB   = 2'd1;
  localparam logic [1:0] ST_BA   = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

endpackage

// File: rtl/bidir_port_fsm.sv
// Direction/turnaround state machine for bidir_port_ctrl.
// Owns the state register and decodes transceiver controls and bus drive enables from it.
// The outputs depend only on the state, so there is no combinational path from the requests.
module bidir_port_fsm
  import am29xx_pkg::*;
(
  input  logic clk,
  input  logic rst_,
  input  logic oea_,
  input  logic oeb_,
  output logic cd,
  output logic tr_,
  output logic drive_a,
  output logic drive_b
);

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Next-state selection: b requests win over a, and a direction reversal always passes through TURN
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_AB: begin
        if (!oeb_)      state_nxt = ST_AB;
        else if (!oea_) state_nxt = ST_TURN;
        else            state_nxt = ST_IDLE;
      end
      ST_BA: begin
        if (!oea_)      state_nxt = ST_BA;
        else if (!oeb_) state_nxt = ST_TURN;
        else            state_nxt = ST_IDLE;
      end
      default: begin
        if (!oeb_)      state_nxt = ST_AB;
        else if (!oea_) state_nxt = ST_BA;
        else            state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; reset parks the port with nothing driven
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign drive_b = (state == ST_AB);
  assign drive_a = (state == ST_BA);
  assign cd      = ~(drive_a | drive_b);
  assign tr_     = ~drive_a;

endmodule

// File: rtl/bidir_port_ctrl.sv
// Registered, handshaken bidirectional bus port (local side a, remote side b).
// Controlling end of an inverting transceiver link: holds the R (a->b) and S (b->a)
// registers with their full flags, a sticky overrun flag, and the tristate drivers.
// INVERT pre-inverts driven data so an inverting transceiver delivers true data.
module bidir_port_ctrl
  import am29xx_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             ldr_,
  input  logic             lds_,
  input  logic             oeb_,
  input  logic             oea_,
  input  logic             clrfr_,
  input  logic             clrfs_,
  output logic             fr,
  output logic             fs,
  output logic             ovr,
  output logic             cd,
  output logic             tr_
);

  localparam logic [WIDTH-1:0] DATA_MASK = {WIDTH{INVERT}};

  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] s_reg;
  logic             drive_a;
  logic             drive_b;

  bidir_port_fsm u_fsm (
    .clk     (clk),
    .rst_    (rst_),
    .oea_    (oea_),
    .oeb_    (oeb_),
    .cd      (cd),
    .tr_     (tr_),
    .drive_a (drive_a),
    .drive_b (drive_b)
  );

  // R captures whatever is on a; a load in the same edge as an acknowledge keeps fr set
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_reg <= '0;
      fr    <= 1'b0;
    end else if (!ldr_) begin
      r_reg <= a;
      fr    <= 1'b1;
    end else if (!clrfr_) begin
      fr    <= 1'b0;
    end
  end

  // S captures whatever is on b, including this port's own drive while in AB
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      s_reg <= '0;
      fs    <= 1'b0;
    end else if (!lds_) begin
      s_reg <= b;
      fs    <= 1'b1;
    end else if (!clrfs_) begin
      fs    <= 1'b0;
    end
  end

  // Sticky overrun: a load into a full register not being acknowledged in the same edge
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ovr <= 1'b0;
    end else if ((!ldr_ && fr && clrfr_) || (!lds_ && fs && clrfs_)) begin
      ovr <= 1'b1;
    end
  end

  assign a = drive_a ? (s_reg ^ DATA_MASK) : {WIDTH{1'bz}};
  assign b = drive_b ? (r_reg ^ DATA_MASK) : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Testbench for bidir_port_ctrl: directed vector table, randomized run against a
// transaction-level model, and an asynchronous reset during an active drive.
// The buses are pulled low, so an undriven bus reads as zero; driven data is kept nonzero.
module tb_bidir_port_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_;
  logic         ldr_, lds_, oea_, oeb_, clrfr_, clrfs_;
  logic         a_en, b_en;
  logic [W-1:0] a_drv, b_drv;

  tri0 [W-1:0] a0, b0, a1, b1;
  wire         fr0, fs0, ovr0, cd0, tr0_;
  wire         fr1, fs1, ovr1, cd1, tr1_;

  assign a0 = a_en ? a_drv : {W{1'bz}};
  assign b0 = b_en ? b_drv : {W{1'bz}};
  assign a1 = a_en ? a_drv : {W{1'bz}};
  assign b1 = b_en ? b_drv : {W{1'bz}};

  bidir_port_ctrl #(.WIDTH(W), .INVERT(1'b0)) u_dut (
    .clk(clk), .rst_(rst_), .a(a0), .b(b0),
    .ldr_(ldr_), .lds_(lds_), .oeb_(oeb_), .oea_(oea_),
    .clrfr_(clrfr_), .clrfs_(clrfs_),
    .fr(fr0), .fs(fs0), .ovr(ovr0), .cd(cd0), .tr_(tr0_)
  );

  bidir_port_ctrl #(.WIDTH(W), .INVERT(1'b1)) u_dut_inv (
    .clk(clk), .rst_(rst_), .a(a1), .b(b1),
    .ldr_(ldr_), .lds_(lds_), .oeb_(oeb_), .oea_(oea_),
    .clrfr_(clrfr_), .clrfs_(clrfs_),
    .fr(fr1), .fs(fs1), .ovr(ovr1), .cd(cd1), .tr_(tr1_)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Directed vector: controls packed as {ldr_, lds_, oea_, oeb_, clrfr_, clrfs_},
  // expected flags packed as {fr, fs, ovr, cd, tr_}
  typedef struct {
    logic [5:0]   ctl;
    logic         a_en;
    logic [W-1:0] a_v;
    logic         b_en;
    logic [W-1:0] b_v;
    logic [4:0]   flags;
    logic [W-1:0] ea, eb, ea1, eb1;
  } vec_t;

  vec_t tbl[$];

  typedef enum {M_IDLE, M_AB, M_BA, M_TURN} mstate_t;

  mstate_t      m_st;
  logic [W-1:0] m_r, m_s;
  logic         m_fr, m_fs, m_ovr;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] ctl, input logic ae, input logic [W-1:0] av,
                               input logic be, input logic [W-1:0] bv);
    {ldr_, lds_, oea_, oeb_, clrfr_, clrfs_} = ctl;
    a_en  = ae;
    a_drv = av;
    b_en  = be;
    b_drv = bv;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [5:0] ctl, input logic ae, input logic [W-1:0] av,
                        input logic be, input logic [W-1:0] bv, input logic [4:0] flags,
                        input logic [W-1:0] ea, input logic [W-1:0] eb,
                        input logic [W-1:0] ea1, input logic [W-1:0] eb1);
    vec_t v;
    v.ctl = ctl; v.a_en = ae; v.a_v = av; v.b_en = be; v.b_v = bv;
    v.flags = flags; v.ea = ea; v.eb = eb; v.ea1 = ea1; v.eb1 = eb1;
    tbl.push_back(v);
  endtask

  // Where the port wants to be next, given its present direction and the two requests
  function automatic mstate_t model_next(mstate_t s, bit want_a, bit want_b);
    if (s == M_AB) return want_b ? M_AB : (want_a ? M_TURN : M_IDLE);
    if (s == M_BA) return want_a ? M_BA : (want_b ? M_TURN : M_IDLE);
    return want_b ? M_AB : (want_a ? M_BA : M_IDLE);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_r = '0; m_s = '0; m_fr = 1'b0; m_fs = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock edge of the non-inverting port, using the input values held before the edge
  task automatic model_edge();
    logic [W-1:0] a_seen, b_seen;
    a_seen = (m_st == M_BA) ? m_s : (a_en ? a_drv : '0);
    b_seen = (m_st == M_AB) ? m_r : (b_en ? b_drv : '0);
    if ((!ldr_ && m_fr && clrfr_) || (!lds_ && m_fs && clrfs_)) m_ovr = 1'b1;
    if (!ldr_) begin m_r = a_seen; m_fr = 1'b1; end
    else if (!clrfr_) m_fr = 1'b0;
    if (!lds_) begin m_s = b_seen; m_fs = 1'b1; end
    else if (!clrfs_) m_fs = 1'b0;
    m_st = model_next(m_st, !oea_, !oeb_);
  endtask

  initial begin
    logic [5:0]   ctl;
    logic         ae, be;
    logic [W-1:0] av, bv, exp_a, exp_b;
    logic         exp_cd, exp_tr;
    mstate_t      nxt;

    rst_ = 1'b0;
    applyStimulus(6'b111111, 1'b0, '0, 1'b0, '0);
    #12;
    checkOutput("reset_flags", {fr0, fs0, ovr0, cd0, tr0_}, 5'b00011);
    checkOutput("reset_a", a0, '0);
    checkOutput("reset_b", b0, '0);
    @(negedge clk);
    rst_ = 1'b1;

    //     ctl        a_en a_v    b_en b_v    fr fs ovr cd tr_ ea     eb     ea1    eb1
    addVec(6'b001111, 1, 8'h33, 1, 8'hAA, 5'b11011, 8'h33, 8'hAA, 8'h33, 8'hAA);
    addVec(6'b111011, 0, 8'h00, 0, 8'h00, 5'b11001, 8'h00, 8'h33, 8'h00, 8'hCC);
    addVec(6'b111001, 0, 8'h00, 0, 8'h00, 5'b01001, 8'h00, 8'h33, 8'h00, 8'hCC);
    addVec(6'b110111, 0, 8'h00, 0, 8'h00, 5'b01011, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b110111, 0, 8'h00, 0, 8'h00, 5'b01000, 8'hAA, 8'h00, 8'h55, 8'h00);
    addVec(6'b110110, 0, 8'h00, 0, 8'h00, 5'b00000, 8'hAA, 8'h00, 8'h55, 8'h00);
    addVec(6'b111111, 0, 8'h00, 0, 8'h00, 5'b00011, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b011111, 1, 8'h5A, 0, 8'h00, 5'b10011, 8'h5A, 8'h00, 8'h5A, 8'h00);
    addVec(6'b011101, 1, 8'h3C, 0, 8'h00, 5'b10011, 8'h3C, 8'h00, 8'h3C, 8'h00);
    addVec(6'b011111, 1, 8'h71, 0, 8'h00, 5'b10111, 8'h71, 8'h00, 8'h71, 8'h00);
    addVec(6'b111101, 0, 8'h00, 0, 8'h00, 5'b00111, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b110011, 0, 8'h00, 0, 8'h00, 5'b00101, 8'h00, 8'h71, 8'h00, 8'h8E);
    addVec(6'b010011, 1, 8'h0F, 0, 8'h00, 5'b10101, 8'h0F, 8'h0F, 8'h0F, 8'hF0);
    addVec(6'b111111, 0, 8'h00, 0, 8'h00, 5'b10111, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b110111, 0, 8'h00, 0, 8'h00, 5'b10100, 8'hAA, 8'h00, 8'h55, 8'h00);
    addVec(6'b111011, 0, 8'h00, 0, 8'h00, 5'b10111, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b111011, 0, 8'h00, 0, 8'h00, 5'b10101, 8'h00, 8'h0F, 8'h00, 8'hF0);
    addVec(6'b101111, 0, 8'h00, 0, 8'h00, 5'b11111, 8'h00, 8'h00, 8'h00, 8'h00);
    addVec(6'b110111, 0, 8'h00, 0, 8'h00, 5'b11100, 8'h0F, 8'h00, 8'h0F, 8'h00);
    addVec(6'b111111, 0, 8'h00, 0, 8'h00, 5'b11111, 8'h00, 8'h00, 8'h00, 8'h00);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].ctl, tbl[i].a_en, tbl[i].a_v, tbl[i].b_en, tbl[i].b_v);
      step();
      checkOutput($sformatf("vec%0d_flags", i), {fr0, fs0, ovr0, cd0, tr0_}, tbl[i].flags);
      checkOutput($sformatf("vec%0d_a", i), a0, tbl[i].ea);
      checkOutput($sformatf("vec%0d_b", i), b0, tbl[i].eb);
      checkOutput($sformatf("vec%0d_a_inv", i), a1, tbl[i].ea1);
      checkOutput($sformatf("vec%0d_b_inv", i), b1, tbl[i].eb1);
    end
    $display("[TB] directed vectors done");

    rst_ = 1'b0;
    applyStimulus(6'b111111, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    rst_ = 1'b1;
    model_reset();

    for (int n = 0; n < 1000; n++) begin
      ctl[5] = ($urandom_range(0, 3) != 0);
      ctl[4] = ($urandom_range(0, 3) != 0);
      ctl[3] = ($urandom_range(0, 2) != 0);
      ctl[2] = ($urandom_range(0, 2) != 0);
      ctl[1] = ($urandom_range(0, 3) != 0);
      ctl[0] = ($urandom_range(0, 3) != 0);
      nxt = model_next(m_st, !ctl[3], !ctl[2]);
      ae  = (m_st != M_BA) && (nxt != M_BA) && ($urandom_range(0, 1) == 1);
      be  = (m_st != M_AB) && (nxt != M_AB) && ($urandom_range(0, 1) == 1);
      av  = W'($urandom_range(1, 255));
      bv  = W'($urandom_range(1, 255));
      applyStimulus(ctl, ae, av, be, bv);
      @(posedge clk);
      model_edge();
      #1;
      exp_a  = (m_st == M_BA) ? m_s : (a_en ? a_drv : '0);
      exp_b  = (m_st == M_AB) ? m_r : (b_en ? b_drv : '0);
      exp_cd = !(m_st == M_AB || m_st == M_BA);
      exp_tr = (m_st != M_BA);
      checkOutput($sformatf("rand%0d", n), {11'd0, fr0, fs0, ovr0, cd0, tr0_, a0, b0},
                  {11'd0, m_fr, m_fs, m_ovr, exp_cd, exp_tr, exp_a, exp_b});
      if (!a_en && !b_en)
        checkOutput($sformatf("rand%0d_contention", n), {31'd0, (a0 != '0) && (b0 != '0)}, 32'd0);
    end
    $display("[TB] random run done");

    applyStimulus(6'b111111, 1'b0, '0, 1'b0, '0);
    step();
    step();
    applyStimulus(6'b011011, 1'b1, 8'hA5, 1'b0, '0);
    step();
    checkOutput("pre_reset_b", b0, 8'hA5);
    checkOutput("pre_reset_cd", cd0, 1'b0);
    applyStimulus(6'b111011, 1'b0, '0, 1'b0, '0);
    #2;
    rst_ = 1'b0;
    #1;
    checkOutput("async_reset_b", b0, '0);
    checkOutput("async_reset_ctl", {fr0, ovr0, cd0, tr0_}, 4'b0011);
    checkOutput("async_reset_b_inv", b1, '0);
    @(negedge clk);
    rst_ = 1'b1;
    applyStimulus(6'b111111, 1'b0, '0, 1'b0, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
